// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter. The in-order writeback always wins the port;
// long-latency completions queue in a FIFO and drain into idle cycles. A
// per-register busy scoreboard feeds the decode hazard check.
module writeback_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_id,
  input  logic [31:0] wb_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_id,
  output logic        issue_ready,
  input  logic        cpl_valid,
  input  logic [4:0]  cpl_id,
  input  logic [31:0] cpl_data,
  output logic        cpl_ready,
  input  logic [4:0]  read1,
  input  logic [4:0]  read2,
  output logic        hazard,
  output logic        stall_req,
  output logic        enable_write,
  output logic [4:0]  write_id,
  output logic [31:0] write_data,
  output logic        err
);

  localparam int unsigned ID_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned AGE_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [ID_W-1:0]   fifo_id_q   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              stall_q, stall_d;
  logic              err_q, err_d;

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              issue_fire;
  logic              outst_dec;
  logic [ID_W-1:0]   head_id;
  logic [DATA_W-1:0] head_data;

  // Circular pointer advance that also works for non-power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Port arbitration, readiness and hazard detection
  assign fifo_empty   = (count_q == '0);
  assign head_id      = fifo_id_q[rd_ptr_q];
  assign head_data    = fifo_data_q[rd_ptr_q];
  assign pop          = !wb_valid && !fifo_empty;
  assign cpl_ready    = (count_q != CNT_W'(DEPTH));
  assign push         = cpl_valid && cpl_ready;
  assign issue_ready  = !busy_q[issue_id] && (outst_q < CNT_W'(DEPTH));
  assign issue_fire   = issue_valid && issue_ready && (issue_id != '0);
  assign outst_dec    = pop && (outst_q != '0);

  assign enable_write = wb_valid || !fifo_empty;
  assign write_id     = wb_valid ? wb_id   : head_id;
  assign write_data   = wb_valid ? wb_data : head_data;

  // Same-cycle drain forwards through the register file, so it is not a hazard
  assign hazard = (busy_q[read1] && !(pop && (head_id == read1))) ||
                  (busy_q[read2] && !(pop && (head_id == read2)));

  assign stall_req = stall_q;
  assign err       = err_q;

  // Next-state for scoreboard, FIFO bookkeeping, starvation and error tracking
  always_comb begin
    busy_d   = busy_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    outst_d  = outst_q;
    age_d    = age_q;
    stall_d  = stall_q;
    err_d    = err_q;

    if (pop) begin
      busy_d[head_id] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (issue_fire) begin
      busy_d[issue_id] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case ({issue_fire, outst_dec})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q < AGE_W'(STARVE_LIMIT)) begin
      age_d = age_q + AGE_W'(1);
    end

    stall_d = (stall_q || (age_q >= AGE_W'(STARVE_LIMIT))) && !pop;

    if (push && !busy_q[cpl_id]) begin
      err_d = 1'b1;
    end
    if (wb_valid && (busy_q[wb_id] || stall_q)) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // FIFO payload storage; validity is tracked by the count, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]   <= cpl_id;
      fifo_data_q[wr_ptr_q] <= cpl_data;
    end
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges the in-order pipeline writeback and out-of-order completions from long-latency units (loads, mul/div) onto the single write port of the register file. It also keeps a per-register scoreboard of pending long-latency destinations, which the decode stage uses to stall. It sits directly upstream of the register file's `enable_write`/`write_id`/`write_data` port. Its `hazard` output goes to decode alongside the register file read ports.

## Interface
- `DEPTH`, default 4: completion FIFO entries; also the maximum number of outstanding long-latency ops.
- `STARVE_LIMIT`, default 8: number of cycles the FIFO head may wait before a pipeline bubble is requested.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_valid` in 1: in-order writeback present; must always be accepted in the same cycle.
- `wb_id` in `reg_id_t`: destination register of the in-order writeback.
- `wb_data` in `op_t`: data of the in-order writeback.
- `issue_valid` in 1: decode is issuing a long-latency op.
- `issue_id` in `reg_id_t`: destination register of the issued op.
- `issue_ready` out 1: issue is accepted this cycle.
- `cpl_valid` in 1: a long-latency unit presents a completion.
- `cpl_id` in `reg_id_t`: destination register of the completion.
- `cpl_data` in `op_t`: result of the completion.
- `cpl_ready` out 1: the FIFO is not full.
- `read1`, `read2` in `reg_id_t`: source registers being read in decode.
- `hazard` out 1: a decode source is still pending.
- `stall_req` out 1: registered request for upstream to withhold `wb_valid`.
- `enable_write` out 1: drives the register file write port.
- `write_id` out `reg_id_t`: drives the register file write port.
- `write_data` out `op_t`: drives the register file write port.
- `err` out 1: sticky protocol-violation flag.

## Operation
- **State:** 32-bit `busy` vector, with bit 0 hardwired to 0. DEPTH-entry FIFO of {id, data}. Outstanding counter of width clog2(DEPTH+1). Head-age counter. `stall_req` flop. `err` flop.
- **Reset:** `busy` is cleared, the FIFO is emptied, the counters are 0, and `stall_req`=0 and `err`=0. Outputs after reset: `enable_write`=0, `hazard`=0, `issue_ready`=1, `cpl_ready`=1. Any in-flight long-latency ops are discarded; the long-latency units are reset in the same cycle.
- **Issue:**
  - `issue_ready` = !`busy[issue_id]` && outstanding < DEPTH.
  - When `issue_valid` && `issue_ready` and `issue_id`≠0, `busy[issue_id]` is set and outstanding increments.
  - `issue_id`=0 is accepted with no scoreboard or counter effect.
- **Completion:**
  - When `cpl_valid` && `cpl_ready`, {`cpl_id`, `cpl_data`} is pushed.
  - The outstanding limit guarantees the FIFO never overflows under legal use.
  - If `cpl_id` is not busy, the completion is still pushed and `err` is set.
- **Write port arbitration (combinational):**
  - If `wb_valid`, the write port drives {1, `wb_id`, `wb_data`}.
  - Otherwise, if the FIFO is non-empty, it drives the FIFO head and pops it.
  - Otherwise, `enable_write`=0.
  - `wb_id`=0 is passed through unchanged; the register file ignores it.
- **Drain:**
  - Popping the head clears `busy[head.id]` and decrements outstanding.
  - An issue and a drain in the same cycle leave outstanding unchanged.
  - An issue and a drain to the same id in the same cycle cannot occur, because `issue_ready` requires the id to be non-busy.
- **WAW check:** `wb_valid` with `busy[wb_id]` set is a protocol violation. The write is still performed and `err` is set.
- **Hazard:**
  - `hazard` = (`busy[read1]` && !draining_to(`read1`)) || (`busy[read2]` && !draining_to(`read2`)).
  - The drain exception is valid because the register file forwards same-cycle write data.
- **Starvation:**
  - The head-age counter increments each cycle the FIFO is non-empty and not popped.
  - It resets to 0 on a pop or when the FIFO is empty.
  - When the age reaches STARVE_LIMIT, `stall_req` is set to 1 on the next edge. It stays 1 until the head pops, then clears on the following edge.
  - Upstream must not assert `wb_valid` while `stall_req`=1. A violating `wb_valid` still wins arbitration and sets `err`.
- **`err`:** cleared only by `rst`.

## Timing
- Issue accepted at edge t: `busy` is visible and `hazard` rises from cycle t+1.
- Completion accepted at edge t: earliest write-port drive is cycle t+1. There is no same-cycle FIFO bypass.
- Drain in cycle d: `hazard` falls combinationally in cycle d, and `busy` is clear from d+1.
- FIFO order is strict FIFO. Completions drain in arrival order, not issue order.
- FIFO full and a pop in the same cycle: `cpl_ready` stays 0 that cycle. Readiness is computed from the registered count only.
- `stall_req` asserts exactly STARVE_LIMIT+1 cycles after a head first waits under continuous `wb_valid`.
- `rst` asserted mid-drain: the pop does not take effect, and all state returns to reset values at that edge.

## Test plan
- **Basic path:** issue id 5 → after 3 cycles, completion {5, 0xDEADBEEF} with `wb_valid`=0 → `enable_write`=1, `write_id`=5, `write_data`=0xDEADBEEF one cycle after acceptance. `hazard` with `read1`=5 is 1 until that cycle, and 0 in it.
- **Priority:** FIFO holds {7, 0x11} while `wb_valid` {3, 0x22} is held for 2 cycles → writes to 3, 3, then 7. `busy[7]` clears only on the third cycle.
- **Limits:** DEPTH=4, issue ids 1–4 → `issue_ready`=0 for id 6. A re-issue of busy id 2 is refused. After one drain, id 6 is accepted.
- **Starvation:** STARVE_LIMIT=8, continuous `wb_valid`, FIFO non-empty → `stall_req`=1 at cycle 9 of waiting. Dropping `wb_valid` drains the head, and `stall_req`=0 the next cycle.
- **Errors:** a completion for non-busy id 9 → `err`=1 and the write still occurs. `wb_valid` to busy id 4 → `err`=1. `err` stays high until `rst`.
- **Reset mid-operation:** 3 pending entries and `rst` pulsed → `busy`=0, FIFO empty, `hazard`=0, `issue_ready`=1, `enable_write`=0 in the cycle after reset.
